// File: rtl/cop_mem_bridge.sv
// cop_mem_bridge: memory-side load/store sequencer for the floating-point coprocessor.
//   Load  (lws): read a word from data memory, push it into a coprocessor register.
//   Store (sws): issue the store opcode, capture the word the coprocessor drives out,
//                write it to data memory.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_*              CPU request handshake and fields (accepted only in IDLE)
//   done / err         one-cycle completion / timeout-abort pulses
//   mem_*              data memory port (held read strobe, single-cycle write strobe)
//   cop_*              coprocessor opcode, register index, write port and read-back
module cop_mem_bridge #(
  parameter int ADDR_W      = 32,
  parameter int RD_TIMEOUT  = 16,
  parameter int CAP_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [4:0]        req_freg,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  output logic [5:0]        cop_opcode,
  output logic [4:0]        cop_reg,
  output logic              cop_wr_en,
  output logic [31:0]       cop_wdata,
  input  logic [31:0]       cop_rdata,
  input  logic              cop_to_mem
);

  localparam int MAX_TO = (RD_TIMEOUT > CAP_TIMEOUT) ? RD_TIMEOUT : CAP_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_TO + 1);

  localparam logic [5:0] OP_IDLE  = 6'b000000;
  localparam logic [5:0] OP_STORE = 6'b111000;

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_WR, ST_ISS, ST_CAP, ST_WR, FIN, ABORT
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        freg_q;
  logic [31:0]       data_q;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      freg_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        freg_q <= req_freg;
      end
      // One buffer serves both directions: load data or store capture.
      if (state == LD_RD && mem_rvalid)
        data_q <= mem_rdata;
      else if (state == ST_CAP && cop_to_mem)
        data_q <= cop_rdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    req_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    cop_opcode = OP_IDLE;
    cop_reg    = '0;
    cop_wr_en  = 1'b0;
    cop_wdata  = '0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = req_store ? ST_ISS : LD_RD;
      end
      LD_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        // Data wins over timeout; abort once the count would reach RD_TIMEOUT.
        if (mem_rvalid)
          state_nxt = LD_WR;
        else if (cnt == CNT_W'(RD_TIMEOUT - 1))
          state_nxt = ABORT;
        else
          cnt_nxt = cnt_inc;
      end
      LD_WR: begin
        cop_wr_en = 1'b1;
        cop_reg   = freg_q;
        cop_wdata = data_q;
        state_nxt = FIN;
      end
      ST_ISS: begin
        cop_opcode = OP_STORE;
        cop_reg    = freg_q;
        state_nxt  = ST_CAP;
      end
      ST_CAP: begin
        if (cop_to_mem)
          state_nxt = ST_WR;
        else if (cnt == CNT_W'(CAP_TIMEOUT - 1))
          state_nxt = ABORT;
        else
          cnt_nxt = cnt_inc;
      end
      ST_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ABORT: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Suppress strobes during the reset cycle so no partial write escapes.
    if (reset) begin
      req_ready  = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      cop_wr_en  = 1'b0;
      cop_opcode = OP_IDLE;
      mem_addr   = '0;
      mem_wdata  = '0;
      cop_reg    = '0;
      cop_wdata  = '0;
    end
  end

endmodule

// File: tb/tb_cop_mem_bridge.sv
// tb_cop_mem_bridge: self-checking bench for cop_mem_bridge.
// Expected per-cycle behaviour is derived from transaction offsets relative to the
// accept cycle; a reference coprocessor register file supplies store data.
module tb_cop_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [4:0]  req_freg;
  logic [31:0] req_addr;
  logic        done, err;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write, mem_rvalid;
  logic [31:0] mem_rdata, mem_wdata;
  logic [5:0]  cop_opcode;
  logic [4:0]  cop_reg;
  logic        cop_wr_en, cop_to_mem;
  logic [31:0] cop_wdata, cop_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_rf [32];

  always #5 clk = ~clk;

  cop_mem_bridge #(
    .ADDR_W(32),
    .RD_TIMEOUT(16),
    .CAP_TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_freg(req_freg), .req_addr(req_addr),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .cop_opcode(cop_opcode), .cop_reg(cop_reg), .cop_wr_en(cop_wr_en),
    .cop_wdata(cop_wdata), .cop_rdata(cop_rdata), .cop_to_mem(cop_to_mem)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_freg   = '0;
    req_addr   = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    cop_to_mem = 1'b0;
    cop_rdata  = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_read, mem_write, cop_wr_en, done, err} !== 6'b100000) begin
      n_bad++;
      $display("FAIL rst_strobes: got %b want %b",
               {req_ready, mem_read, mem_write, cop_wr_en, done, err}, 6'b100000);
    end
    n_cmp++;
    if (cop_opcode !== 6'b000000) begin
      n_bad++;
      $display("FAIL rst_opcode: got %b want 000000", cop_opcode);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, cop_wdata, cop_reg} !== '0) begin
      n_bad++;
      $display("FAIL rst_buses: got %h %h %h %h want zero", mem_addr, mem_wdata, cop_wdata, cop_reg);
    end
    next_cycle();
  endtask

  // k = cycle (1-based, from first mem_read cycle) carrying mem_rvalid; k <= 0 means never.
  task automatic test_load(input logic [4:0] f, input logic [31:0] a, input logic [31:0] d, input int k);
    bit ok = (k >= 1 && k <= 16);
    int nread = ok ? k : 16;
    int last = ok ? k + 2 : 17;
    logic [5:0] got, exp;
    req_valid = 1'b1; req_store = 1'b0; req_freg = f; req_addr = a;
    for (int i = 0; i <= last; i++) begin
      if (i == 1) begin
        req_valid = 1'b0; req_store = 1'($urandom); req_freg = 5'($urandom); req_addr = $urandom;
      end
      mem_rvalid = (k > 0 && i == k) ? 1'b1 : ((i > nread) ? 1'($urandom) : 1'b0);
      mem_rdata  = (k > 0 && i == k) ? d : $urandom;
      @(negedge clk);
      got = {req_ready, mem_read, mem_write, cop_wr_en, done, err};
      exp = {(i == 0), (i >= 1 && i <= nread), 1'b0, (ok && i == k + 1), (ok && i == last), (!ok && i == last)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL ld_strobes i=%0d k=%0d: got %b want %b", i, k, got, exp);
      end
      n_cmp++;
      if (cop_opcode !== 6'b000000) begin
        n_bad++;
        $display("FAIL ld_opcode i=%0d: got %b want 000000", i, cop_opcode);
      end
      if (i >= 1 && i <= nread) begin
        n_cmp++;
        if (mem_addr !== a) begin
          n_bad++;
          $display("FAIL ld_addr i=%0d: got %h want %h", i, mem_addr, a);
        end
      end
      if (ok && i == k + 1) begin
        n_cmp++;
        if ({cop_reg, cop_wdata} !== {f, d}) begin
          n_bad++;
          $display("FAIL ld_copwr: got reg %0d data %h want reg %0d data %h", cop_reg, cop_wdata, f, d);
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ld_ready_after: got %b want 1", req_ready);
    end
    if (ok) ref_rf[f] = d;
    next_cycle();
  endtask

  // dly = ST_CAP cycles before cop_to_mem rises (0 = nominal).
  task automatic test_store(input logic [4:0] f, input logic [31:0] a, input int dly);
    bit ok = (dly >= 0 && dly <= 3);
    int cap = 2 + dly;
    int last = ok ? cap + 2 : 6;
    logic [31:0] sval = ref_rf[f];
    logic [5:0] got, exp, exp_op;
    req_valid = 1'b1; req_store = 1'b1; req_freg = f; req_addr = a;
    for (int i = 0; i <= last; i++) begin
      if (i == 1) begin
        req_valid = 1'b0; req_store = 1'($urandom); req_freg = 5'($urandom); req_addr = $urandom;
      end
      cop_to_mem = (i == cap);
      cop_rdata  = (i == cap) ? sval : $urandom;
      @(negedge clk);
      got = {req_ready, mem_read, mem_write, cop_wr_en, done, err};
      exp = {(i == 0), 1'b0, (ok && i == cap + 1), 1'b0, (ok && i == last), (!ok && i == last)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL st_strobes i=%0d dly=%0d: got %b want %b", i, dly, got, exp);
      end
      exp_op = (i == 1) ? 6'b111000 : 6'b000000;
      n_cmp++;
      if (cop_opcode !== exp_op) begin
        n_bad++;
        $display("FAIL st_opcode i=%0d: got %b want %b", i, cop_opcode, exp_op);
      end
      if (i == 1) begin
        n_cmp++;
        if (cop_reg !== f) begin
          n_bad++;
          $display("FAIL st_reg: got %0d want %0d", cop_reg, f);
        end
      end
      if (ok && i == cap + 1) begin
        n_cmp++;
        if ({mem_addr, mem_wdata} !== {a, sval}) begin
          n_bad++;
          $display("FAIL st_memwr: got %h/%h want %h/%h", mem_addr, mem_wdata, a, sval);
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL st_ready_after: got %b want 1", req_ready);
    end
    next_cycle();
  endtask

  task automatic test_mid_reset;
    logic [5:0] got;
    req_valid = 1'b1; req_store = 1'b0; req_freg = 5'($urandom); req_addr = $urandom;
    next_cycle();
    req_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_read !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_mid_read i=%0d: got %b want 1", i, mem_read);
      end
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    got = {req_ready, mem_read, mem_write, cop_wr_en, done, err};
    n_cmp++;
    if (got !== 6'b100000) begin
      n_bad++;
      $display("FAIL rst_mid_strobes: got %b want 100000", got);
    end
    n_cmp++;
    if ({cop_opcode, mem_addr, mem_wdata, cop_wdata, cop_reg} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_buses: got %b %h %h %h %h want zero",
               cop_opcode, mem_addr, mem_wdata, cop_wdata, cop_reg);
    end
    next_cycle();
  endtask

  // Store then load with req_valid held high; load accepted the cycle after the store's done.
  task automatic test_back_to_back(input logic [4:0] sf, input logic [31:0] sa,
                                   input logic [4:0] lf, input logic [31:0] la,
                                   input logic [31:0] ld, input int k);
    logic [31:0] sval = ref_rf[sf];
    int last = 7 + k;
    logic [5:0] got, exp, exp_op;
    req_valid = 1'b1; req_store = 1'b1; req_freg = sf; req_addr = sa;
    for (int i = 0; i <= last; i++) begin
      if (i == 1) begin
        req_store = 1'b0; req_freg = lf; req_addr = la;
      end
      if (i == last) req_valid = 1'b0;
      cop_to_mem = (i == 2);
      cop_rdata  = (i == 2) ? sval : $urandom;
      mem_rvalid = (i == 5 + k);
      mem_rdata  = (i == 5 + k) ? ld : $urandom;
      @(negedge clk);
      got = {req_ready, mem_read, mem_write, cop_wr_en, done, err};
      exp = {(i == 0 || i == 5), (i >= 6 && i <= 5 + k), (i == 3), (i == 6 + k),
             (i == 4 || i == 7 + k), 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL b2b_strobes i=%0d k=%0d: got %b want %b", i, k, got, exp);
      end
      exp_op = (i == 1) ? 6'b111000 : 6'b000000;
      n_cmp++;
      if (cop_opcode !== exp_op) begin
        n_bad++;
        $display("FAIL b2b_opcode i=%0d: got %b want %b", i, cop_opcode, exp_op);
      end
      if (i == 3) begin
        n_cmp++;
        if ({mem_addr, mem_wdata} !== {sa, sval}) begin
          n_bad++;
          $display("FAIL b2b_memwr: got %h/%h want %h/%h", mem_addr, mem_wdata, sa, sval);
        end
      end
      if (i == 6 + k) begin
        n_cmp++;
        if ({cop_reg, cop_wdata} !== {lf, ld}) begin
          n_bad++;
          $display("FAIL b2b_copwr: got reg %0d data %h want reg %0d data %h", cop_reg, cop_wdata, lf, ld);
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_after: got %b want 1", req_ready);
    end
    ref_rf[lf] = ld;
    next_cycle();
  endtask

  initial begin
    logic [4:0]  f, f2;
    logic [31:0] a, a2, d;
    int unsigned pick;
    reset = 1'b1;
    idle_inputs();
    for (int unsigned r = 0; r < 32; r++) ref_rf[r] = $urandom;

    test_reset();
    test_load(5'd5, 32'h40, 32'h40490FDB, 3);
    ref_rf[7] = 32'hC0200000;
    test_store(5'd7, 32'h80, 0);
    test_load(5'd3, 32'h100, 32'h12345678, 0);
    test_store(5'd2, 32'h84, 99);
    test_mid_reset();
    test_load(5'd1, 32'h44, 32'h3F800000, 2);
    test_load(5'd9, 32'h48, 32'hDEADBEEF, 16);
    test_load(5'd10, 32'h4C, 32'hCAFEF00D, 1);
    test_load(5'd11, 32'h50, 32'h0BADF00D, 17);
    test_store(5'd9, 32'h88, 3);
    test_store(5'd10, 32'h8C, 4);
    test_back_to_back(5'd7, 32'h90, 5'd12, 32'h94, 32'h41200000, 2);

    for (int n = 0; n < 30; n++) begin
      pick = $urandom_range(0, 2);
      f  = 5'($urandom);
      f2 = 5'($urandom);
      a  = $urandom;
      a2 = $urandom;
      d  = $urandom;
      case (pick)
        0:       test_load(f, a, d, int'($urandom_range(0, 17)));
        1:       test_store(f, a, int'($urandom_range(0, 4)));
        default: test_back_to_back(f, a, f2, a2, d, int'($urandom_range(1, 16)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
